// File: rtl/fixed_point.sv
// Signed fixed-point number format shared by the vector datapath blocks.
package fixed_point;

  localparam int unsigned FIXED_W          = 16;
  localparam int unsigned FIXED_FRACTION_W = 8;

  typedef logic signed [FIXED_W-1:0] fixed_point_t;

  // Largest positive representable value, used as the saturation level.
  localparam fixed_point_t FIXED_MAX = fixed_point_t'({1'b0, {(FIXED_W-1){1'b1}}});

endpackage

// File: rtl/vector.sv
// Three-component fixed-point vector type.
package vector;

  import fixed_point::*;

  localparam int unsigned VECTOR_N = 3;

  typedef fixed_point_t [VECTOR_N-1:0] vector_t;

endpackage

// File: rtl/vector_dot_product.sv
// Combinational dot product of two fixed-point vectors, rescaled to
// fixed_point_t with an overflow flag when the sum does not fit.
module vector_dot_product
  import fixed_point::*;
  import vector::*;
(
  input  vector_t      i_op1,
  input  vector_t      i_op2,
  output fixed_point_t o_result_c,
  output logic         o_overflow_c
);

  localparam int unsigned PROD_W = 2 * FIXED_W;
  localparam int unsigned SUM_W  = PROD_W + $clog2(VECTOR_N) + 1;

  logic signed [PROD_W-1:0] w_prod [VECTOR_N];
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_scaled;

  // Full-precision sum of products, then drop the extra fraction bits.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < VECTOR_N; i++) begin
      w_prod[i] = $signed(i_op1[i]) * $signed(i_op2[i]);
      w_sum     = w_sum + SUM_W'(w_prod[i]);
    end
    w_scaled     = w_sum >>> FIXED_FRACTION_W;
    o_result_c   = w_scaled[FIXED_W-1:0];
    o_overflow_c = (w_scaled[SUM_W-1:FIXED_W-1] != '0) &&
                   (w_scaled[SUM_W-1:FIXED_W-1] != '1);
  end

endmodule

// File: rtl/vector_magnitude.sv
// Euclidean length of a fixed-point vector: dot product with itself followed
// by a bit-serial square root, one result bit per cycle, fixed latency.
module vector_magnitude
  import fixed_point::*;
  import vector::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  vector_t      op,
  output logic         result_valid,
  input  logic         result_ready,
  output fixed_point_t result,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOT  = 2'd1,
    SQRT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned ITER_N = FIXED_W - 1;
  localparam int unsigned IDX_W  = $clog2(ITER_N);
  localparam int unsigned PROD_W = 2 * FIXED_W;

  state_e             r_state, w_state_nxt;
  vector_t            r_op, w_op_nxt;
  fixed_point_t       r_dot, w_dot_nxt;
  logic               r_dot_ovf, w_dot_ovf_nxt;
  logic [FIXED_W-1:0] r_root, w_root_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  fixed_point_t       r_result, w_result_nxt;
  logic               r_overflow, w_overflow_nxt;
  logic               r_op_ready, w_op_ready_nxt;
  logic               r_result_valid, w_result_valid_nxt;

  fixed_point_t       w_dp_result;
  logic               w_dp_ovf;
  logic [IDX_W-1:0]   w_bit_pos;
  logic [FIXED_W-1:0] w_test_bit;
  logic [FIXED_W-1:0] w_cand;
  logic [PROD_W-1:0]  w_cand_sq;
  logic [PROD_W-1:0]  w_dot_ext;
  logic [PROD_W-1:0]  w_dot_scaled;
  logic               w_take;

  vector_dot_product u_dot (
    .i_op1        (r_op),
    .i_op2        (r_op),
    .o_result_c   (w_dp_result),
    .o_overflow_c (w_dp_ovf)
  );

  // Square-root trial: keep the candidate bit if its square does not exceed dot.
  always_comb begin
    w_bit_pos    = IDX_W'(ITER_N - 1) - r_idx;
    w_test_bit   = FIXED_W'(1) << w_bit_pos;
    w_cand       = r_root | w_test_bit;
    w_cand_sq    = PROD_W'(w_cand) * PROD_W'(w_cand);
    w_dot_ext    = {{FIXED_W{1'b0}}, r_dot};
    w_dot_scaled = w_dot_ext << FIXED_FRACTION_W;
    w_take       = (w_cand_sq <= w_dot_scaled);
  end

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_dot_nxt      = r_dot;
    w_dot_ovf_nxt  = r_dot_ovf;
    w_root_nxt     = r_root;
    w_idx_nxt      = r_idx;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;

    case (r_state)
      IDLE: begin
        if (op_valid && r_op_ready) begin
          w_op_nxt    = op;
          w_state_nxt = DOT;
        end
      end
      DOT: begin
        w_dot_nxt     = w_dp_result;
        w_dot_ovf_nxt = w_dp_ovf;
        w_root_nxt    = '0;
        w_idx_nxt     = '0;
        w_state_nxt   = SQRT;
      end
      SQRT: begin
        if (w_take) begin
          w_root_nxt = w_cand;
        end
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(ITER_N - 1)) begin
          w_result_nxt   = r_dot_ovf ? FIXED_MAX : fixed_point_t'(w_root_nxt);
          w_overflow_nxt = r_dot_ovf;
          w_state_nxt    = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_op_ready_nxt     = (w_state_nxt == IDLE);
    w_result_valid_nxt = (w_state_nxt == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_op           <= '0;
      r_dot          <= '0;
      r_dot_ovf      <= 1'b0;
      r_root         <= '0;
      r_idx          <= '0;
      r_result       <= '0;
      r_overflow     <= 1'b0;
      r_op_ready     <= 1'b1;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_op           <= w_op_nxt;
      r_dot          <= w_dot_nxt;
      r_dot_ovf      <= w_dot_ovf_nxt;
      r_root         <= w_root_nxt;
      r_idx          <= w_idx_nxt;
      r_result       <= w_result_nxt;
      r_overflow     <= w_overflow_nxt;
      r_op_ready     <= w_op_ready_nxt;
      r_result_valid <= w_result_valid_nxt;
    end
  end

  assign op_ready     = r_op_ready;
  assign result_valid = r_result_valid;
  assign result       = r_result;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_vector_magnitude.sv
// Directed self-checking bench for vector_magnitude.
module tb_vector_magnitude;

  import fixed_point::*;
  import vector::*;

  logic         clk;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  vector_t      op;
  logic         result_valid;
  logic         result_ready;
  fixed_point_t result;
  logic         overflow;

  int n_checks;
  int n_pass;

  vector_magnitude dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op           (op),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vector_t mk(input fixed_point_t x, input fixed_point_t y, input fixed_point_t z);
    vector_t v;
    v[0] = x;
    v[1] = y;
    v[2] = z;
    return v;
  endfunction

  // Reference: exact integer sum of squares, floor rescale, binary-search root.
  function automatic void model(input vector_t v, output fixed_point_t r, output logic ovf);
    longint s, d, lo, hi, mid;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      longint c;
      c = longint'($signed(v[i]));
      s = s + c * c;
    end
    d = s / 256;
    if (d > 32767) begin
      ovf = 1'b1;
      r   = 16'sh7FFF;
    end else begin
      ovf = 1'b0;
      lo  = 0;
      hi  = 32767;
      while (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (mid * mid <= d * 256) lo = mid;
        else hi = mid - 1;
      end
      r = fixed_point_t'(lo);
    end
  endfunction

  // Present v, wait for result_valid; lat counts edges from acceptance, -1 on timeout.
  task automatic do_op(input vector_t v, output int lat);
    op       = v;
    op_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    op_valid = 1'b0;
    op       = vector_t'({$urandom(), $urandom()});
    while (result_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (result_valid !== 1'b1) lat = -1;
  endtask

  task automatic consume();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL reset_op_ready: got %b want 1", op_ready); else n_pass++;
    n_checks++;
    if (result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b want 0", result_valid); else n_pass++;
    n_checks++;
    if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    do_op(mk(16'sh0300, 16'sh0400, 16'sh0000), lat);
    n_checks++;
    if (lat != 17) $display("FAIL basic_latency: got %0d want 17", lat); else n_pass++;
    n_checks++;
    if (result !== 16'h0500) $display("FAIL basic_result: got %h want 0500", result); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", overflow); else n_pass++;
    consume();
    n_checks++;
    if (result_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", result_valid); else n_pass++;
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", op_ready); else n_pass++;
    n_checks++;
    if (result !== 16'h0500) $display("FAIL basic_result_held: got %h want 0500", result); else n_pass++;
  endtask

  task automatic test_unit_zero();
    int lat;
    do_op(mk(16'sh0100, 16'sh0000, 16'sh0000), lat);
    n_checks++;
    if (result !== 16'h0100) $display("FAIL unit_result: got %h want 0100", result); else n_pass++;
    n_checks++;
    if (lat != 17) $display("FAIL unit_latency: got %0d want 17", lat); else n_pass++;
    consume();
    do_op(mk(16'sh0000, 16'sh0000, 16'sh0000), lat);
    n_checks++;
    if (result !== 16'h0000) $display("FAIL zero_result: got %h want 0000", result); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL zero_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++;
    if (lat != 17) $display("FAIL zero_latency: got %0d want 17", lat); else n_pass++;
    consume();
    // A single-LSB component squares to below one LSB, so the root is zero.
    do_op(mk(16'sh0000, 16'sh0000, 16'sh0001), lat);
    n_checks++;
    if (result !== 16'h0000) $display("FAIL tiny_result: got %h want 0000", result); else n_pass++;
    consume();
  endtask

  task automatic test_sqrt2_and_mixed();
    int           lat;
    fixed_point_t exp_r;
    logic         exp_o;
    vector_t      v;
    v = mk(16'sh0000, 16'sh0100, 16'sh0100);
    model(v, exp_r, exp_o);
    do_op(v, lat);
    n_checks++;
    if (result !== exp_r) $display("FAIL sqrt2_model: got %h want %h", result, exp_r); else n_pass++;
    n_checks++;
    if (result !== 16'h016A) $display("FAIL sqrt2_const: got %h want 016a", result); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL sqrt2_overflow: got %b want 0", overflow); else n_pass++;
    consume();
    // Negative components: (-3,-4,0) -> 5.0
    do_op(mk(16'shFD00, 16'shFC00, 16'sh0000), lat);
    n_checks++;
    if (result !== 16'h0500) $display("FAIL neg_result: got %h want 0500", result); else n_pass++;
    consume();
    // (1.5,-2.25,0.75): dot 7.875 -> 718 LSBs
    v = mk(16'sh0180, 16'shFDC0, 16'sh00C0);
    model(v, exp_r, exp_o);
    do_op(v, lat);
    n_checks++;
    if (result !== exp_r || overflow !== exp_o)
      $display("FAIL mixed_model: got %h/%b want %h/%b", result, overflow, exp_r, exp_o);
    else n_pass++;
    n_checks++;
    if (result !== 16'h02CE) $display("FAIL mixed_const: got %h want 02ce", result); else n_pass++;
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    do_op(mk(16'sh7FFF, 16'sh7FFF, 16'sh7FFF), lat);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL max_overflow: got %b want 1", overflow); else n_pass++;
    n_checks++;
    if (result !== 16'h7FFF) $display("FAIL max_result: got %h want 7fff", result); else n_pass++;
    n_checks++;
    if (lat != 17) $display("FAIL max_latency: got %0d want 17", lat); else n_pass++;
    consume();
    // 11.25^2 = 126.5625 still fits.
    do_op(mk(16'sh0B40, 16'sh0000, 16'sh0000), lat);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL edge_fit_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++;
    if (result !== 16'h0B40) $display("FAIL edge_fit_result: got %h want 0b40", result); else n_pass++;
    consume();
    // 11.375^2 = 129.39 exceeds the format.
    do_op(mk(16'sh0B60, 16'sh0000, 16'sh0000), lat);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL edge_over_overflow: got %b want 1", overflow); else n_pass++;
    n_checks++;
    if (result !== 16'h7FFF) $display("FAIL edge_over_result: got %h want 7fff", result); else n_pass++;
    consume();
    // Overflow clears on the next normal op.
    do_op(mk(16'sh0100, 16'sh0000, 16'sh0000), lat);
    n_checks++;
    if (overflow !== 1'b0 || result !== 16'h0100)
      $display("FAIL after_ovf: got %h/%b want 0100/0", result, overflow);
    else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    result_ready = 1'b0;
    do_op(mk(16'sh0300, 16'sh0400, 16'sh0000), lat);
    n_checks++;
    if (lat != 17) $display("FAIL bp_latency: got %0d want 17", lat); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (result_valid !== 1'b1) $display("FAIL bp_valid_%0d: got %b want 1", c, result_valid); else n_pass++;
      n_checks++;
      if (result !== 16'h0500 || overflow !== 1'b0)
        $display("FAIL bp_result_%0d: got %h/%b want 0500/0", c, result, overflow);
      else n_pass++;
      n_checks++;
      if (op_ready !== 1'b0) $display("FAIL bp_op_ready_%0d: got %b want 0", c, op_ready); else n_pass++;
      op_valid = (c == 1);
      op       = mk(16'sh0100, 16'sh0000, 16'sh0000);
      @(posedge clk);
      @(negedge clk);
    end
    op_valid     = 1'b0;
    result_ready = 1'b1;
    consume();
    n_checks++;
    if (result_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", result_valid); else n_pass++;
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", op_ready); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (result_valid !== 1'b0 || result !== 16'h0500)
      $display("FAIL bp_ignored_op: got valid %b result %h want 0/0500", result_valid, result);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    op       = mk(16'sh0100, 16'sh0000, 16'sh0000);
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (op_ready !== 1'b1) $display("FAIL rst_mid_op_ready: got %b want 1", op_ready); else n_pass++;
    n_checks++;
    if (result_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", result_valid); else n_pass++;
    n_checks++;
    if (result !== 16'h0000) $display("FAIL rst_mid_result: got %h want 0000", result); else n_pass++;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL rst_mid_overflow: got %b want 0", overflow); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rst_mid_stale_valid: got %b want 0", seen); else n_pass++;
    // New op presented on the same cycle reset releases.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(mk(16'sh0300, 16'sh0400, 16'sh0000), lat);
    n_checks++;
    if (lat != 17) $display("FAIL rst_release_latency: got %0d want 17", lat); else n_pass++;
    n_checks++;
    if (result !== 16'h0500 || overflow !== 1'b0)
      $display("FAIL rst_release_result: got %h/%b want 0500/0", result, overflow);
    else n_pass++;
    consume();
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    op_valid     = 1'b0;
    op           = '0;
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_unit_zero();
    test_sqrt2_and_mixed();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vector_magnitude.md
VECTOR_MAGNITUDE -- requirements
Module: vector_magnitude

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port op_valid  input  1  op holds a vector to measure.
REQ-004 SHALL have port op_ready  output  1  block can accept op this cycle.
REQ-005 SHALL have port op  input  vector::vector_t  operand vector.
REQ-006 SHALL have port result_valid  output  1  result/overflow hold the answer.
REQ-007 SHALL have port result_ready  input  1  consumer takes the result this cycle.
REQ-008 SHALL have port result  output  fixed_point::fixed_point_t  |op|, non-negative fixed point.
REQ-009 SHALL have port overflow  output  1  dot product of op with itself overflowed; result is saturated.

Function
REQ-010 SHALL implement FSM states IDLE, DOT, SQRT, DONE.
REQ-011 SHALL drive op_ready=1 only in IDLE; acceptance is op_valid & op_ready at a rising edge, moving IDLE->DOT and capturing op.
REQ-012 SHALL in DOT register the dot product of op with itself and its overflow flag, clear the root accumulator and the bit index, then move DOT->SQRT.
REQ-013 SHALL in SQRT run FIXED_W-1 iterations, one per cycle, testing bit positions FIXED_W-2 down to 0 (sign bit never set).
REQ-014 SHALL in each iteration form candidate = root | test_bit, and set root = candidate when the 2*FIXED_W-bit unsigned product candidate*candidate <= (dot << FIXED_FRACTION_W); otherwise root is unchanged.
REQ-015 SHALL make the comparison exact, with no intermediate truncation; the result is floor(sqrt(dot)) at fixed-point LSB resolution.
REQ-016 SHALL on a registered dot overflow skip the iterations' effect and load result = maximum positive fixed_point_t with overflow=1; otherwise overflow=0.
REQ-017 SHALL leave SQRT for DONE after the iteration at bit 0, with result and overflow registered.
REQ-018 SHALL hold result_valid=1 in DONE and keep result and overflow stable until result_valid & result_ready at a rising edge, then move to IDLE.
REQ-019 SHALL take exactly FIXED_W+1 rising edges from the acceptance edge to result_valid rising, including the acceptance edge; this latency is independent of data.
REQ-020 SHALL accept no new op in DOT, SQRT or DONE; op_valid is ignored there and op may change freely after acceptance.
REQ-021 SHALL hold result and overflow at their last values outside DONE; only result_valid qualifies them.
REQ-022 SHALL produce result = 0 for a zero vector, with overflow=0.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force state IDLE, op_ready=1, result_valid=0, result=0, overflow=0, and clear root, dot register and bit index.
REQ-024 SHALL discard any in-flight computation when reset asserts mid-operation, with no result_valid pulse afterwards.
REQ-025 SHALL accept a new op on the first rising edge after rst_n deasserts when op_valid=1.

Structure
REQ-026 SHALL take fixed_point_t, FIXED_W and FIXED_FRACTION_W from the fixed_point package, and vector_t from the vector package; no new package types are added.
REQ-027 SHALL define the FSM state enum locally in the module.
REQ-028 SHALL instantiate one existing vector_dot_product (op1=op2=captured op) as its only sub-module; squaring and compare are inline.

Verification
REQ-029 SHALL cover: op=(3.0,4.0,0.0) accepted, result_ready=1 -> result=5.0 exactly, overflow=0, result_valid FIXED_W+1 edges after acceptance.
REQ-030 SHALL cover: op=(1.0,0.0,0.0) -> result=1.0; op=(0,0,0) -> result=0, overflow=0.
REQ-031 SHALL cover: op=(0.0,1.0,1.0) -> result=floor(sqrt(2)*2^FIXED_FRACTION_W) LSBs, checked against the bit-true model.
REQ-032 SHALL cover: op components at maximum positive value -> overflow=1, result=maximum positive fixed_point_t.
REQ-033 SHALL cover: result_ready=0 for 5 cycles in DONE -> result and result_valid stable, op_ready=0, a concurrent op_valid pulse ignored; release -> IDLE on the next edge.
REQ-034 SHALL cover: rst_n pulsed low mid-SQRT -> outputs at reset values immediately, no stale result_valid, and the next op returns a correct result.
